// File: rtl/sim_monitor_pkg.sv
// Shared definitions for sim_monitor: FSM encodings, default decode addresses,
// and the exit code reported on a timeout halt.
package sim_monitor_pkg;
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } mon_state_t;

  localparam logic [23:0] DEF_TERM_ADDR    = 24'hFFFFFF;
  localparam logic [23:0] DEF_CH_BASE_ADDR = 24'hFFFFFE;
  localparam logic [7:0]  TIMEOUT_CODE     = 8'hFF;
endpackage

// File: rtl/mon_fifo.sv
// Byte FIFO for one console channel. The caller qualifies push/pop; a push
// into a full FIFO only succeeds when a pop frees the slot in the same cycle,
// otherwise the byte is dropped and the sticky overflow flag is set.
module mon_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       valid,
  output logic       ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic        full, do_push;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_push = push & (~full | pop);
  assign valid   = (cnt != '0);
  assign head    = mem[rp];

  // Storage array; no reset needed, occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // Pointers, occupancy and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      case ({do_push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push & full & ~pop) ovf <= 1'b1;
    end
  end
endmodule

// File: rtl/sim_monitor.sv
// CPU data-port monitor: console channel FIFOs, terminate/exit-code capture,
// and (with SIM_MONITOR_STATS_EN defined) cycle/instruction counters plus a
// run timeout. Without the macro the stats outputs are tied to zero.
module sim_monitor
  import sim_monitor_pkg::*;
#(
  parameter int                ADDR_W         = 24,
  parameter int                DATA_W         = 32,
  parameter int                NUM_CH         = 2,
  parameter int                FIFO_DEPTH     = 16,
  parameter logic [ADDR_W-1:0] TERM_ADDR      = DEF_TERM_ADDR,
  parameter logic [ADDR_W-1:0] CH_BASE_ADDR   = DEF_CH_BASE_ADDR,
  parameter int                TIMEOUT_CYCLES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clk_en,
  input  logic [ADDR_W-1:0]     i_daddr,
  input  logic [DATA_W-1:0]     i_dout,
  input  logic                  i_wr,
  input  logic                  i_instr_valid,
  output logic [NUM_CH-1:0]     o_ch_valid,
  output logic [8*NUM_CH-1:0]   o_ch_data,
  input  logic [NUM_CH-1:0]     i_ch_ready,
  output logic [NUM_CH-1:0]     o_ch_ovf,
  output logic                  o_halt,
  output logic [7:0]            o_exit_code,
  output logic                  o_timeout,
  output logic [31:0]           o_cycle_count,
  output logic [31:0]           o_instr_count
);
  mon_state_t state, state_nxt;
  logic run, wr_run, term_hit, to_fire;
  logic [NUM_CH-1:0]      push, pop;
  logic [NUM_CH-1:0][7:0] heads;
  logic unused_hi;

  assign run      = (state == RUN);
  assign wr_run   = i_clk_en & i_wr & run;
  assign term_hit = wr_run & (i_daddr == TERM_ADDR);
  assign o_halt   = (state == HALTED);
  assign o_ch_data = heads;
  assign unused_hi = ^i_dout[DATA_W-1:8];

  genvar n;
  generate
    for (n = 0; n < NUM_CH; n++) begin : g_ch
      assign push[n] = wr_run & (i_daddr == (CH_BASE_ADDR - ADDR_W'(n)));
      assign pop[n]  = o_ch_valid[n] & i_ch_ready[n] & i_clk_en;
      mon_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push[n]),
        .pop   (pop[n]),
        .din   (i_dout[7:0]),
        .head  (heads[n]),
        .valid (o_ch_valid[n]),
        .ovf   (o_ch_ovf[n])
      );
    end
  endgenerate

  // State register; holds while the clock enable is low.
  always_ff @(posedge i_clk) begin
    if (i_rst)         state <= RUN;
    else if (i_clk_en) state <= state_nxt;
  end

  // Next state: stop on terminate or timeout, halt once every FIFO drained.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (term_hit | to_fire) state_nxt = DRAIN;
      DRAIN:   if (~|o_ch_valid)       state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  // Exit code is captured once, on leaving RUN; terminate beats timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_exit_code <= '0;
    else if (i_clk_en & run) begin
      if (term_hit)     o_exit_code <= i_dout[7:0];
      else if (to_fire) o_exit_code <= TIMEOUT_CODE;
    end
  end

`ifdef SIM_MONITOR_STATS_EN
  logic [31:0] cyc_cnt, ins_cnt;
  logic        to_flag;

  assign to_fire = (TIMEOUT_CYCLES != 0) && run && i_clk_en &&
                   (cyc_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign o_cycle_count = cyc_cnt;
  assign o_instr_count = ins_cnt;
  assign o_timeout     = to_flag;

  // Saturating counters, advancing only in RUN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else if (i_clk_en & run) begin
      if (cyc_cnt != '1)                  cyc_cnt <= cyc_cnt + 1'b1;
      if (i_instr_valid && ins_cnt != '1) ins_cnt <= ins_cnt + 1'b1;
    end
  end

  // Timeout flag only when the timeout, not a terminate, ended the run.
  always_ff @(posedge i_clk) begin
    if (i_rst)                          to_flag <= 1'b0;
    else if (to_fire & ~term_hit)       to_flag <= 1'b1;
  end
`else
  logic unused_stats;
  assign unused_stats  = ^{i_instr_valid, 32'(TIMEOUT_CYCLES)};
  assign to_fire       = 1'b0;
  assign o_cycle_count = '0;
  assign o_instr_count = '0;
  assign o_timeout     = 1'b0;
`endif
endmodule

// File: tb/tb_sim_monitor.sv
// Directed bench for sim_monitor: a per-cycle vector table for console FIFO
// behaviour, then hand sequences for overflow, drain/halt, reset in DRAIN,
// clock-enable counting and the timeout paths. Build with or without
// SIM_MONITOR_STATS_EN; stats expectations follow the macro.
module tb_sim_monitor;
`ifdef SIM_MONITOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst, i_clk_en, i_wr, i_instr_valid;
  logic [23:0] i_daddr;
  logic [31:0] i_dout;
  logic [1:0]  i_ch_ready, o_ch_valid, o_ch_ovf;
  logic [15:0] o_ch_data;
  logic        o_halt, o_timeout;
  logic [7:0]  o_exit_code;
  logic [31:0] o_cycle_count, o_instr_count;

  int vecs = 0;
  int miss = 0;

  sim_monitor #(
    .ADDR_W(24), .DATA_W(32), .NUM_CH(2), .FIFO_DEPTH(16),
    .TERM_ADDR(24'hFFFFFF), .CH_BASE_ADDR(24'hFFFFFE), .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .i_daddr(i_daddr),
    .i_dout(i_dout), .i_wr(i_wr), .i_instr_valid(i_instr_valid),
    .o_ch_valid(o_ch_valid), .o_ch_data(o_ch_data), .i_ch_ready(i_ch_ready),
    .o_ch_ovf(o_ch_ovf), .o_halt(o_halt), .o_exit_code(o_exit_code),
    .o_timeout(o_timeout), .o_cycle_count(o_cycle_count),
    .o_instr_count(o_instr_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        en, wr;
    logic [23:0] addr;
    logic [7:0]  data;
    logic [1:0]  rdy;
    logic [1:0]  ev;
    logic [7:0]  eh0, eh1;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_clk_en = 1'b1; i_wr = 1'b0; i_ch_ready = 2'b00; i_instr_valid = 1'b0;
    i_daddr = '0; i_dout = '0;
  endtask

  task automatic do_reset();
    idle();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
  endtask

  task automatic wr_byte(input logic [23:0] a, input logic [7:0] d);
    i_wr = 1'b1; i_daddr = a; i_dout = {24'h0, d};
    step();
    i_wr = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {30'h0, o_ch_valid}, 0);
    chk({tag, "_ovf"},   {30'h0, o_ch_ovf}, 0);
    chk({tag, "_halt"},  {31'h0, o_halt}, 0);
    chk({tag, "_exit"},  {24'h0, o_exit_code}, 0);
    chk({tag, "_tmo"},   {31'h0, o_timeout}, 0);
    chk({tag, "_cyc"},   o_cycle_count, 0);
    chk({tag, "_ins"},   o_instr_count, 0);
  endtask

  initial begin
    int n;
    logic [7:0] exp_b;

    //      en wr addr          data   rdy    ev     eh0    eh1
    tbl[0] = '{1, 1, 24'hFFFFFE, 8'h41, 2'b00, 2'b01, 8'h41, 8'h00};
    tbl[1] = '{1, 1, 24'hFFFFFE, 8'h42, 2'b00, 2'b01, 8'h41, 8'h00};
    tbl[2] = '{1, 0, 24'h000000, 8'h00, 2'b00, 2'b01, 8'h41, 8'h00};
    tbl[3] = '{1, 0, 24'h000000, 8'h00, 2'b01, 2'b01, 8'h42, 8'h00};
    tbl[4] = '{1, 0, 24'h000000, 8'h00, 2'b01, 2'b00, 8'h00, 8'h00};
    tbl[5] = '{1, 0, 24'h000000, 8'h00, 2'b11, 2'b00, 8'h00, 8'h00};
    tbl[6] = '{1, 1, 24'hFFFFFD, 8'h7A, 2'b00, 2'b10, 8'h00, 8'h7A};
    tbl[7] = '{1, 1, 24'hFFFFFC, 8'h55, 2'b00, 2'b10, 8'h00, 8'h7A};
    tbl[8] = '{1, 0, 24'h000000, 8'h00, 2'b10, 2'b00, 8'h00, 8'h00};
    tbl[9] = '{0, 1, 24'hFFFFFE, 8'h33, 2'b00, 2'b00, 8'h00, 8'h00};

    // Reset state
    do_reset();
    chk_zero("rst");

    // Table: console push/pop timing, decode, clock-enable write loss
    for (int i = 0; i < 10; i++) begin
      i_clk_en = tbl[i].en; i_wr = tbl[i].wr; i_daddr = tbl[i].addr;
      i_dout = {24'h0, tbl[i].data}; i_ch_ready = tbl[i].rdy;
      step();
      chk($sformatf("t%0d_valid", i), {30'h0, o_ch_valid}, {30'h0, tbl[i].ev});
      if (tbl[i].ev[0]) chk($sformatf("t%0d_head0", i), {24'h0, o_ch_data[7:0]}, {24'h0, tbl[i].eh0});
      if (tbl[i].ev[1]) chk($sformatf("t%0d_head1", i), {24'h0, o_ch_data[15:8]}, {24'h0, tbl[i].eh1});
      chk($sformatf("t%0d_ovf", i), {30'h0, o_ch_ovf}, 0);
      chk($sformatf("t%0d_halt", i), {31'h0, o_halt}, 0);
    end
    idle();

    // Overflow: fill channel 1, push+pop at full, then drop one byte
    do_reset();
    for (int i = 0; i < 16; i++) wr_byte(24'hFFFFFD, 8'(i));
    chk("full_ovf", {30'h0, o_ch_ovf}, 0);
    chk("full_head", {24'h0, o_ch_data[15:8]}, 0);
    i_ch_ready = 2'b10;
    wr_byte(24'hFFFFFD, 8'hAA);
    i_ch_ready = 2'b00;
    chk("pp_ovf", {30'h0, o_ch_ovf}, 0);
    chk("pp_head", {24'h0, o_ch_data[15:8]}, 1);
    wr_byte(24'hFFFFFD, 8'hBB);
    chk("drop_ovf", {30'h0, o_ch_ovf}, 2);
    i_ch_ready = 2'b10;
    for (int i = 1; i <= 16; i++) begin
      exp_b = (i == 16) ? 8'hAA : 8'(i);
      chk($sformatf("drain_v%0d", i), {31'h0, o_ch_valid[1]}, 1);
      chk($sformatf("drain_b%0d", i), {24'h0, o_ch_data[15:8]}, {24'h0, exp_b});
      step();
    end
    chk("drain_empty", {30'h0, o_ch_valid}, 0);
    chk("drain_ovf_sticky", {30'h0, o_ch_ovf}, 2);
    idle();

    // Terminate with queued bytes; later writes ignored; halt after drain
    do_reset();
    wr_byte(24'hFFFFFE, 8'h11);
    wr_byte(24'hFFFFFE, 8'h22);
    wr_byte(24'hFFFFFF, 8'h05);
    wr_byte(24'hFFFFFE, 8'h77);
    wr_byte(24'hFFFFFF, 8'h09);
    chk("term_exit", {24'h0, o_exit_code}, 8'h05);
    chk("term_nohalt", {31'h0, o_halt}, 0);
    chk("term_head0", {24'h0, o_ch_data[7:0]}, 8'h11);
    i_ch_ready = 2'b01;
    step();
    chk("term_head1", {24'h0, o_ch_data[7:0]}, 8'h22);
    step();
    chk("term_empty", {30'h0, o_ch_valid}, 0);
    chk("term_halt_early", {31'h0, o_halt}, 0);
    step();
    chk("term_halt", {31'h0, o_halt}, 1);
    chk("term_exit_kept", {24'h0, o_exit_code}, 8'h05);
    chk("term_tmo", {31'h0, o_timeout}, 0);
    chk("term_cyc_frozen", o_cycle_count, STATS ? 32'd3 : 32'd0);
    idle();

    // Reset while in DRAIN with clock enable low
    do_reset();
    wr_byte(24'hFFFFFE, 8'h12);
    wr_byte(24'hFFFFFF, 8'h07);
    chk("dr_exit", {24'h0, o_exit_code}, 8'h07);
    chk("dr_valid", {30'h0, o_ch_valid}, 1);
    i_clk_en = 1'b0; i_rst = 1'b1;
    step();
    i_rst = 1'b0; i_clk_en = 1'b1;
    chk_zero("dr_rst");
    wr_byte(24'hFFFFFE, 8'h66);
    chk("dr_run_valid", {30'h0, o_ch_valid}, 1);
    chk("dr_run_head", {24'h0, o_ch_data[7:0]}, 8'h66);

    // Clock enable toggled during an instruction stream
    do_reset();
    i_instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      i_clk_en = i[0];
      step();
    end
    idle();
    chk("en_ins", o_instr_count, STATS ? 32'd10 : 32'd0);
    chk("en_cyc", o_cycle_count, STATS ? 32'd10 : 32'd0);

    // Timeout with no terminate
    do_reset();
    n = 0;
    while (!o_halt && n < 200) begin
      step();
      n++;
    end
    chk("to_halt", {31'h0, o_halt}, {31'h0, STATS});
    chk("to_latency", {31'h0, (n >= 101 && n <= 102)}, {31'h0, STATS});
    chk("to_flag", {31'h0, o_timeout}, {31'h0, STATS});
    chk("to_exit", {24'h0, o_exit_code}, STATS ? 32'hFF : 32'h0);
    chk("to_cyc", o_cycle_count, STATS ? 32'd100 : 32'd0);

    // Terminate in the same cycle the timeout fires
    do_reset();
    for (int i = 0; i < 99; i++) step();
    wr_byte(24'hFFFFFF, 8'h3C);
    step();
    chk("tt_halt", {31'h0, o_halt}, 1);
    chk("tt_tmo", {31'h0, o_timeout}, 0);
    chk("tt_exit", {24'h0, o_exit_code}, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
